serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage directly upstream of the serial pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `out`, which drives the detector's `in`.
- A one-word holding buffer lets back-to-back words stream with no idle bit between them.
- Also flags the last bit of each word so downstream logic can align detections to word boundaries.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on `out` when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word.
- data_valid  input  1  data_in holds a word.
- data_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit; connects to the detector's `in`.
- out_valid  output  1  `out` carries a word bit this cycle.
- word_done  output  1  current `out` bit is the last bit of its word.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: state=IDLE, shift_reg=0, bit_cnt=0, hold_full=0.
- Outputs during and after reset: out=IDLE_BIT, out_valid=0, word_done=0. data_ready=0 while rst=1 and 1 in the first cycle after.
- Reset mid-word: the word in flight and the held word are discarded. No partial bits follow.
- Accept: a word is taken on a rising edge where data_valid && data_ready.
- data_ready = !hold_full && !rst. It is a function of registers and rst only, never of data_valid.
- States:
  - IDLE: out=IDLE_BIT, out_valid=0. An accept loads data_in into shift_reg, clears bit_cnt, and moves to SHIFT.
  - SHIFT: out = current bit of shift_reg (selected by MSB_FIRST), out_valid=1. Each cycle bit_cnt increments and shift_reg advances by one bit.
- Latency: the first bit appears on `out` in the cycle after the accept edge. A word occupies exactly WIDTH consecutive cycles.
- word_done = (state==SHIFT && bit_cnt==WIDTH-1).
- Accept while in SHIFT: the word goes to hold_reg and hold_full is set.
- At the last-bit edge, the next word is chosen in this priority:
  - hold_full: hold_reg moves to shift_reg and hold_full clears. An accept in the same cycle is impossible because ready=0.
  - else an accept on that edge: data_in moves straight to shift_reg.
  - else: return to IDLE.
  - In the first two cases state stays SHIFT and bit_cnt returns to 0 with no gap cycle.
- Backpressure: once hold_full=1, data_ready stays low until the hold word is moved. The maximum sustained rate is one word per WIDTH cycles.
- Outputs are derived only from flops (state, shift_reg, bit_cnt), never from inputs combinationally.
- Arithmetic: bit_cnt is $clog2(WIDTH) bits wide. It wraps only by explicit reload to 0, never by overflow.
- data_in is ignored whenever there is no accept.

Decomposition:
- Shared package serial_pkg:
  - feeder state typedef {IDLE, SHIFT}.
  - Default IDLE_BIT and WIDTH constants, also used by the detector bench.
- One sub-module is natural: word_hold_buf. It holds the one-entry holding register plus hold_full flag, with load/take strobes. Shift control and bit selection stay in the top level.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles with data_valid=1. Expect data_ready=0, out=0, out_valid=0, word_done=0 throughout; nothing accepted.
- Single word: WIDTH=8, MSB_FIRST=1, send 0x88. Expect out = 1,0,0,0,1,0,0,0 in the 8 cycles after accept. word_done is high only on the 8th bit. The downstream detector asserts its output on the 5th bit.
- LSB-first: MSB_FIRST=0, send 0x11. Expect the same sequence 1,0,0,0,1,0,0,0.
- Back-to-back: 0xA5 then 0x3C presented continuously. Expect 16 contiguous out_valid cycles with bits 10100101 00111100. data_ready drops after the second accept and rises on the edge where 0x3C moves to shift_reg.
- Last-bit accept with empty hold: send 0xFF, then assert data_valid with 0x00 only in the cycle where word_done=1. Expect 0x00 to start on the next cycle with no gap.
- Reset mid-operation: assert rst on bit 3 of 0xF0 with 0x0F held. Expect out=IDLE_BIT and out_valid=0 the next cycle; neither word resumes.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial feeder and the pattern detector bench.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

    localparam int   DEFAULT_WIDTH    = 8;
    localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry holding register that parks the next word while the current one shifts out.
module word_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_take,
    output logic             o_full,
    output logic [WIDTH-1:0] o_word
);

    logic             r_full;
    logic [WIDTH-1:0] r_word;

    // Load and take never coincide: take needs the buffer full, which blocks any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_word <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_word <= i_word;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_word = r_word;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: one word in over valid/ready, one bit per clock out, with
// a holding buffer so consecutive words stream without a gap.
module serial_bit_feeder
    import serial_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             word_done,
    output feeder_state_t    o_dbg_state
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    feeder_state_t    r_state, w_state_n;
    logic [WIDTH-1:0] r_shift, w_shift_n, w_shift_adv;
    logic [CW-1:0]    r_cnt, w_cnt_n;

    logic             w_accept, w_last, w_load, w_take, w_hold_full;
    logic [WIDTH-1:0] w_hold_word;

    // Handshake: a word transfers on a rising edge where data_valid && data_ready.
    // data_ready depends only on the hold flag and rst, never on data_valid.
    assign data_ready = !w_hold_full && !rst;
    assign w_accept   = data_valid && data_ready;
    assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_CNT);

    // A word accepted mid-shift parks; one accepted on the last bit goes straight to the shifter.
    assign w_load = w_accept && (r_state == SHIFT) && !w_last;
    assign w_take = w_last && w_hold_full;

    word_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_word (data_in),
        .i_take (w_take),
        .o_full (w_hold_full),
        .o_word (w_hold_word)
    );

    assign w_shift_adv = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_cnt_n   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_n = SHIFT;
                    w_shift_n = data_in;
                    w_cnt_n   = '0;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_shift_n = w_shift_adv;
                    w_cnt_n   = r_cnt + 1'b1;
                end else if (w_hold_full) begin
                    w_shift_n = w_hold_word;
                    w_cnt_n   = '0;
                end else if (w_accept) begin
                    w_shift_n = data_in;
                    w_cnt_n   = '0;
                end else begin
                    w_state_n = IDLE;
                    w_shift_n = '0;
                    w_cnt_n   = '0;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign out_valid   = (r_state == SHIFT);
    assign out         = out_valid ? (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]) : IDLE_BIT;
    assign word_done   = w_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an MSB-first and an LSB-first instance share stimulus and are
// compared each cycle against a queue of the bits still owed to the line.
module tb_serial_bit_feeder;
    import serial_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;

    logic          m_ready, m_out, m_valid, m_done;
    logic          l_ready, l_out, l_valid, l_done;
    feeder_state_t m_state, l_state;

    int total = 0;
    int bad   = 0;

    // Bits not yet driven, in line order, one queue per bit ordering.
    logic exp_m[$];
    logic exp_l[$];

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(m_ready), .out(m_out), .out_valid(m_valid), .word_done(m_done),
        .o_dbg_state(m_state)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(l_ready), .out(l_out), .out_valid(l_valid), .word_done(l_done),
        .o_dbg_state(l_state)
    );

    // At most one word in flight plus one parked: room exists while no more than a word is owed.
    function automatic logic model_ready();
        return !rst && (exp_m.size() <= W);
    endfunction

    always @(posedge clk) begin
        logic acc;
        acc = data_valid && model_ready();
        if (rst) begin
            exp_m.delete();
            exp_l.delete();
        end else begin
            if (exp_m.size() > 0) begin
                void'(exp_m.pop_front());
                void'(exp_l.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    exp_m.push_back(data_in[W-1-i]);
                    exp_l.push_back(data_in[i]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after a falling edge, check outputs, then move to the next one.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, output logic acc);
        logic           ev, eo_m, eo_l, ed, er;
        feeder_state_t  es;
        rst        = r;
        data_valid = v;
        data_in    = d;
        #1;
        ev   = (exp_m.size() > 0);
        eo_m = ev ? exp_m[0] : 1'b0;
        eo_l = ev ? exp_l[0] : 1'b1;
        ed   = ev && ((exp_m.size() % W) == 1);
        er   = model_ready();
        es   = ev ? SHIFT : IDLE;
        acc  = v && er;
        check("msb_ready", m_ready, er);
        check("msb_out",   m_out,   eo_m);
        check("msb_valid", m_valid, ev);
        check("msb_done",  m_done,  ed);
        check("msb_state", m_state === es, 1'b1);
        check("lsb_ready", l_ready, er);
        check("lsb_out",   l_out,   eo_l);
        check("lsb_valid", l_valid, ev);
        check("lsb_done",  l_done,  ed);
        check("lsb_state", l_state === es, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), acc);
    endtask

    task automatic send(input logic [W-1:0] w);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 4 * W && !acc; i++) step(1'b0, 1'b1, w, acc);
        check("send_accepted", acc, 1'b1);
    endtask

    initial begin
        logic acc;
        @(negedge clk);

        // Reset held with valid asserted: nothing may be taken.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, W'($urandom), acc);
        idle(2);

        send(8'h88); idle(W + 2);
        send(8'h11); idle(W + 2);

        // Back-to-back words stream with no gap.
        send(8'hA5); send(8'h3C); idle(2 * W + 2);

        // Second word offered only while the last bit of the first is on the line.
        send(8'hFF);
        for (int i = 0; i < 2 * W && !((exp_m.size() % W) == 1); i++) idle(1);
        step(1'b0, 1'b1, 8'h00, acc);
        check("last_bit_accept", acc, 1'b1);
        idle(W + 2);

        // Reset while bit 3 of 0xF0 is out and 0x0F is parked.
        send(8'hF0); send(8'h0F);
        for (int i = 0; i < 2 * W && exp_m.size() != W + 5; i++) idle(1);
        check("parked_before_reset", exp_m.size() == W + 5, 1'b1);
        step(1'b1, 1'b0, 8'h00, acc);
        idle(W + 2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, W'($urandom), acc);
        end
        idle(2 * W + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
